vram_read_arbiter: RTL

Shares the single read port of the on-chip background/sprite image RAM among four pixel requesters: background scan-out, enemy sprites, player sprite and shot sprite. Background scan-out (requester 0) has strict priority because it is real-time against DrawX/DrawY. Requesters 1..3 share the remaining slots round-robin, with an optional lock so one requester can hold consecutive beats for a line burst. Read data returns after a fixed latency, tagged by a one-hot valid to the requester that issued it.

---
 rtl/vram_read_arbiter_pkg.sv | 25 ++
 rtl/vram_read_arbiter_rr_pick.sv | 27 ++
 rtl/vram_read_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/vram_read_arbiter_pkg.sv
// Shared sizing defaults, requester ids and pixel word layout for the VRAM read arbiter.
package vram_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned RD_LAT  = 2;

  localparam int unsigned REQ_BG     = 0;
  localparam int unsigned REQ_ENEMY  = 1;
  localparam int unsigned REQ_PLAYER = 2;
  localparam int unsigned REQ_SHOT   = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Round-robin successor over requesters 1..n-1; requester 0 never enters the ring.
  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k >= n - 1) ? 1 : k + 1;
  endfunction

endpackage

// File: rtl/vram_read_arbiter_rr_pick.sv
// Combinational round-robin picker over requesters 1..NUM_REQ-1, scanning from i_rr with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RR_W    = 2
) (
  input  logic [NUM_REQ-1:1] i_req,
  input  logic [RR_W-1:0]    i_rr,
  output logic               o_valid,
  output logic [RR_W-1:0]    o_idx
);

  function automatic int unsigned scan_idx(input logic [RR_W-1:0] rr, input int unsigned off);
    return ((32'(rr) + off - 1) % (NUM_REQ - 1)) + 1;
  endfunction

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
      if (!o_valid && i_req[scan_idx(i_rr, off)]) begin
        o_valid = 1'b1;
        o_idx   = RR_W'(scan_idx(i_rr, off));
      end
    end
  end

endmodule

// File: rtl/vram_read_arbiter.sv
// Single-port image RAM read arbiter: fixed priority for background scan-out,
// round-robin with burst lock for sprites, RD_LAT+1 cycle tagged response.
module vram_read_arbiter #(
  parameter int unsigned NUM_REQ = vram_arb_pkg::NUM_REQ,
  parameter int unsigned ADDR_W  = vram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W  = vram_arb_pkg::DATA_W,
  parameter int unsigned RD_LAT  = vram_arb_pkg::RD_LAT
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_re,
  input  logic [DATA_W-1:0]         mem_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  import vram_arb_pkg::*;

  localparam int unsigned RR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [RR_W-1:0]    r_rr;
  logic [RR_W-1:0]    r_owner;
  logic               r_lock_active;
  logic [NUM_REQ-1:0] r_tag [RD_LAT];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  logic               w_rr_valid;
  logic [RR_W-1:0]    w_rr_idx;
  logic               w_win_valid;
  logic [RR_W-1:0]    w_win_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ADDR_W-1:0]  w_mem_addr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .RR_W    (RR_W)
  ) u_rr_pick (
    .i_req   (req[NUM_REQ-1:1]),
    .i_rr    (r_rr),
    .o_valid (w_rr_valid),
    .o_idx   (w_rr_idx)
  );

  // Winner: background first, then a live lock owner, then the round-robin ring.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    if (!Reset_n) begin
      w_win_valid = 1'b0;
    end else if (req[REQ_BG]) begin
      w_win_valid = 1'b1;
      w_win_idx   = RR_W'(REQ_BG);
    end else if (r_lock_active && req[r_owner]) begin
      w_win_valid = 1'b1;
      w_win_idx   = r_owner;
    end else if (w_rr_valid) begin
      w_win_valid = 1'b1;
      w_win_idx   = w_rr_idx;
    end
  end

  always_comb begin
    w_gnt      = '0;
    w_mem_addr = '0;
    if (w_win_valid) begin
      w_gnt[w_win_idx] = 1'b1;
      w_mem_addr       = addr[32'(w_win_idx)*ADDR_W +: ADDR_W];
    end
  end

  assign gnt      = w_gnt;
  assign mem_addr = w_mem_addr;
  assign mem_re   = |w_gnt;

  // A background beat neither advances the ring nor touches the lock, so the owner resumes.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_rr          <= RR_W'(1);
      r_owner       <= '0;
      r_lock_active <= 1'b0;
    end else if (w_win_valid && (w_win_idx != '0)) begin
      r_rr          <= RR_W'(rr_next(32'(w_win_idx), NUM_REQ));
      r_lock_active <= lock[w_win_idx];
      if (lock[w_win_idx]) begin
        r_owner <= w_win_idx;
      end
    end else if (r_lock_active && !req[r_owner]) begin
      r_lock_active <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '0;
      end
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_tag[0] <= w_gnt;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_rsp_valid <= r_tag[RD_LAT-1];
      r_rsp_data  <= mem_data;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
